alu_param_core: RTL and testbench
=================================

Name: alu_param_core

Overview:
Parametrised, registered ALU core. It is the next generation of the team's 8-bit ALU, with generic operand width and two-operand capture across cycles using inp_valid and a timeout. It adds a 2-cycle pipelined multiply with issue stall and rotate-by-B operations. It is the DUT behind the alu_if-style testbench interface, with res widened to 2*WIDTH and res_valid/busy added.

Parameters:
WIDTH, 8, operand width in bits (>=4, power of 2)
TIMEOUT, 16, number of ce-qualified cycles to wait for a missing operand
SH_W, $clog2(WIDTH), rotate-amount width (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
ce  input  1  clock enable; low freezes all state
mode  input  1  1 = arithmetic, 0 = logical
cmd  input  4  operation code
inp_valid  input  2  bit0 = op_a valid, bit1 = op_b valid
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
cin  input  1  carry in
res  output  2*WIDTH  result
res_valid  output  1  one-cycle pulse: res and flags updated
busy  output  1  high while a multiply occupies the stall slot
cout  output  1  carry out
oflow  output  1  borrow/overflow
err  output  1  illegal command, illegal rotate amount, or timeout
G, E, L  output  1 each  compare flags

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM to IDLE, counter 0, multiply pipe flushed. No res_valid is produced for in-flight work.
- ce=0: every register holds, including FSM, counter and multiply stage. res_valid is forced 0.
- FSM states: IDLE, WAIT_A, WAIT_B.
  - IDLE, iv=11: capture both operands, cmd, mode and cin, then execute.
  - IDLE, iv=01: if cmd needs only A (INC_A, DEC_A, NOT_A, SHR1_A, SHL1_A), execute. Otherwise capture A, cmd, mode and cin, and go to WAIT_B.
  - IDLE, iv=10: symmetric to iv=01 (B-only cmds; otherwise go to WAIT_A).
  - IDLE, iv=00: no operation.
  - WAIT_x: cmd, mode and cin stay as latched. The missing operand's valid bit captures that operand and executes. The other valid bit is ignored. The counter increments on each ce=1 cycle.
  - Timeout: if the missing operand has not arrived by counter==TIMEOUT, issue err=1, res=0, res_valid=1 on the next cycle, then return to IDLE.
- Latency: single-cycle ops produce res_valid 1 cycle after execution. MUL ops produce it 2 cycles after. busy=1 in the intervening cycle, and any input presented while busy=1 is ignored.
- Arithmetic (mode=1) cmd encoding:
  - 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B
  - 8 CMP
  - 9 MUL_INC: (A+1)*(B+1)
  - 10 MUL_SHL: (A<<1)*B, computed mod 2^WIDTH before the multiply
  - 11-15 illegal
- Logical (mode=0) cmd encoding:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR
  - 6 NOT_A, 7 NOT_B
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B
  - 12 ROL_A_B, 13 ROR_A_B
  - 14-15 illegal
- Width rules:
  - Add/inc: res[WIDTH] = cout = carry. Upper bits are 0.
  - Sub/dec: res is the WIDTH-bit two's-complement result, oflow=1 on borrow (A<B, or DEC of 0).
  - Logical results are zero-extended.
  - MUL results use all 2*WIDTH bits.
- CMP: exactly one of G/E/L is set, res=0. G/E/L are 0 for every other cmd.
- Rotate: amount = B[SH_W-1:0]. Any set bit in B[WIDTH-1:SH_W] gives err=1, res=0.
- Illegal cmd: err=1, res=0, res_valid pulses.
- Flags not relevant to the executed op are 0 whenever res_valid pulses. res and flags hold between pulses.

Optional Feature:
ALU_SAT_EN:
- Defined: ADD, ADD_CIN and INC saturate res to all-ones in WIDTH bits, with res[WIDTH]=0, and still assert cout. SUB, SUB_CIN and DEC clamp to 0 and still assert oflow.
- Undefined: wrap-around behaviour as specified above.

Decomposition:
- alu_pkg holds:
  - arith_cmd_e and logic_cmd_e enums
  - inp_valid encoding constants
  - the state_e enum (IDLE/WAIT_A/WAIT_B)
  - functions needs_a(), needs_b() and is_mul(cmd, mode)
- Sub-module alu_param_mul: 2-stage registered WIDTH x WIDTH multiplier with ce and async active-low rst.

Test Plan:
- WIDTH=8, mode=1 cmd=0 A=FF B=01 iv=11 -> next cycle res=0x0100, cout=1, res_valid=1. With ALU_SAT_EN -> res=0x00FF, cout=1.
- mode=1 cmd=9 A=3 B=4 -> res=0x0014 two cycles later, busy=1 in between. An ADD presented in the busy cycle produces no result.
- mode=1 cmd=0 iv=01 A=5, then iv=10 B=7 ten cycles later -> res=12 the following cycle. Repeating with B never sent -> err=1, res=0, res_valid at cycle TIMEOUT+1.
- CMP A=9 B=9 -> E=1, G=L=0. A=10 B=9 -> G=1. SUB A=3 B=5 -> res=0xFE, oflow=1.
- mode=0 cmd=12 A=0x81 B=1 -> res=0x03. B=0x09 -> err=1, res=0. mode=0 cmd=15 -> err=1.
- Assert rst=0 mid-WAIT_B and again mid-multiply -> all outputs 0 immediately, no res_valid after release, FSM in IDLE. Hold ce=0 for 5 cycles mid-multiply -> result appears 5 cycles late and is unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for alu_param_core: command enums, operand-valid
// encodings, the operand-capture FSM state, and command classification.
package alu_pkg;

    typedef enum logic [3:0] {
        A_ADD     = 4'd0,
        A_SUB     = 4'd1,
        A_ADD_CIN = 4'd2,
        A_SUB_CIN = 4'd3,
        A_INC_A   = 4'd4,
        A_DEC_A   = 4'd5,
        A_INC_B   = 4'd6,
        A_DEC_B   = 4'd7,
        A_CMP     = 4'd8,
        A_MUL_INC = 4'd9,
        A_MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        L_AND    = 4'd0,
        L_NAND   = 4'd1,
        L_OR     = 4'd2,
        L_NOR    = 4'd3,
        L_XOR    = 4'd4,
        L_XNOR   = 4'd5,
        L_NOT_A  = 4'd6,
        L_NOT_B  = 4'd7,
        L_SHR1_A = 4'd8,
        L_SHL1_A = 4'd9,
        L_SHR1_B = 4'd10,
        L_SHL1_B = 4'd11,
        L_ROL    = 4'd12,
        L_ROR    = 4'd13
    } logic_cmd_e;

    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_AB   = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_e;

    // Illegal commands report as needing both operands, so a lone operand
    // parks the FSM and the error surfaces once the pair is complete.
    function automatic logic needs_a(input logic [3:0] cmd, input logic mode);
        if (mode) return !(cmd == A_INC_B || cmd == A_DEC_B);
        return !(cmd == L_NOT_B || cmd == L_SHR1_B || cmd == L_SHL1_B);
    endfunction

    function automatic logic needs_b(input logic [3:0] cmd, input logic mode);
        if (mode) return !(cmd == A_INC_A || cmd == A_DEC_A);
        return !(cmd == L_NOT_A || cmd == L_SHR1_A || cmd == L_SHL1_A);
    endfunction

    function automatic logic is_mul(input logic [3:0] cmd, input logic mode);
        return mode && (cmd == A_MUL_INC || cmd == A_MUL_SHL);
    endfunction

endpackage

// File: rtl/alu_param_mul.sv
// Two-stage multiplier: stage 1 registers the operands, stage 2 registers
// the product truncated to OUT_W. ce freezes both stages.
module alu_param_mul #(
    parameter int OP_W  = 9,
    parameter int OUT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic             i_vld,
    input  logic [OP_W-1:0]  i_a,
    input  logic [OP_W-1:0]  i_b,
    output logic             o_busy,
    output logic             o_vld,
    output logic [OUT_W-1:0] o_p
);

    logic [OP_W-1:0]  r_a;
    logic [OP_W-1:0]  r_b;
    logic [OUT_W-1:0] r_p;
    logic [1:0]       r_vld_pipe;

    // Operand and product stages advance together with the valid shift register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_p        <= '0;
            r_vld_pipe <= '0;
        end else if (i_ce) begin
            r_vld_pipe <= {r_vld_pipe[0], i_vld};
            if (i_vld) begin
                r_a <= i_a;
                r_b <= i_b;
            end
            if (r_vld_pipe[0]) r_p <= OUT_W'(r_a) * OUT_W'(r_b);
        end
    end

    assign o_busy = r_vld_pipe[0];
    assign o_vld  = r_vld_pipe[1];
    assign o_p    = r_p;

endmodule

// File: rtl/alu_param_core.sv
// Registered parametric ALU with split-operand capture (WAIT_A/WAIT_B plus
// timeout) and a stalling 2-cycle multiply. Optional macro ALU_SAT_EN makes
// add/inc saturate to all-ones and sub/dec clamp to zero.
module alu_param_core
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ce,
    input  logic               i_mode,
    input  logic [3:0]         i_cmd,
    input  logic [1:0]         i_inp_valid,
    input  logic [WIDTH-1:0]   i_op_a,
    input  logic [WIDTH-1:0]   i_op_b,
    input  logic               i_cin,
    output logic [2*WIDTH-1:0] o_res,
    output logic               o_res_valid,
    output logic               o_busy,
    output logic               o_cout,
    output logic               o_oflow,
    output logic               o_err,
    output logic               o_g,
    output logic               o_e,
    output logic               o_l
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [WIDTH:0] K1       = {{WIDTH{1'b0}}, 1'b1};

    state_e             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [3:0]         r_cmd;
    logic               r_mode, r_cin;
    logic [2*WIDTH-1:0] r_res;
    logic               r_cout, r_oflow, r_err, r_g, r_e, r_l, r_valid;

    logic               w_go, w_tmo, w_lat_a, w_lat_b, w_lat_ctl;
    logic [WIDTH-1:0]   w_a, w_b;
    logic [3:0]         w_cmd;
    logic               w_mode, w_cin;
    logic               w_is_mul, w_mul_go, w_sc_go;
    logic               w_busy, w_mul_vld;
    logic [2*WIDTH-1:0] w_mul_p;
    logic [WIDTH:0]     w_ma, w_mb;

    logic [2*WIDTH-1:0] c_res;
    logic               c_cout, c_oflow, c_err, c_g, c_e, c_l;
    logic [WIDTH:0]     w_t;
    logic [WIDTH-1:0]   w_lw;
    logic [2*WIDTH-1:0] w_rot;
    logic               w_add, w_sub, w_log;

    // Operand-capture FSM: choose operand sources, decide execute/timeout, next state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_go        = 1'b0;
        w_tmo       = 1'b0;
        w_lat_a     = 1'b0;
        w_lat_b     = 1'b0;
        w_lat_ctl   = 1'b0;
        w_a         = i_op_a;
        w_b         = i_op_b;
        w_cmd       = i_cmd;
        w_mode      = i_mode;
        w_cin       = i_cin;
        if (!w_busy) begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    case (i_inp_valid)
                        IV_AB: w_go = 1'b1;
                        IV_A: begin
                            if (!needs_b(i_cmd, i_mode)) w_go = 1'b1;
                            else begin
                                w_lat_a     = 1'b1;
                                w_lat_ctl   = 1'b1;
                                w_state_nxt = WAIT_B;
                            end
                        end
                        IV_B: begin
                            if (!needs_a(i_cmd, i_mode)) w_go = 1'b1;
                            else begin
                                w_lat_b     = 1'b1;
                                w_lat_ctl   = 1'b1;
                                w_state_nxt = WAIT_A;
                            end
                        end
                        default: ;
                    endcase
                end
                WAIT_B, WAIT_A: begin
                    w_cmd  = r_cmd;
                    w_mode = r_mode;
                    w_cin  = r_cin;
                    if (r_state == WAIT_B) w_a = r_a;
                    else                   w_b = r_b;
                    if (r_state == WAIT_B ? i_inp_valid[1] : i_inp_valid[0]) begin
                        w_go        = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == TMO_LAST) begin
                        w_tmo       = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_is_mul = is_mul(w_cmd, w_mode);
    assign w_mul_go = w_go & w_is_mul;
    assign w_sc_go  = (w_go & ~w_is_mul) | w_tmo;

    // MUL_INC widens to WIDTH+1 so (2^W)*(B+1) is not lost; MUL_SHL wraps A<<1 first
    assign w_ma = (w_cmd == A_MUL_INC) ? ({1'b0, w_a} + K1) : {1'b0, w_a[WIDTH-2:0], 1'b0};
    assign w_mb = (w_cmd == A_MUL_INC) ? ({1'b0, w_b} + K1) : {1'b0, w_b};

    alu_param_mul #(.OP_W(WIDTH + 1), .OUT_W(2 * WIDTH)) u_mul (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_ce   (i_ce),
        .i_vld  (w_mul_go),
        .i_a    (w_ma),
        .i_b    (w_mb),
        .o_busy (w_busy),
        .o_vld  (w_mul_vld),
        .o_p    (w_mul_p)
    );

    // Single-cycle datapath: result and flags for the executing command
    always_comb begin
        c_res   = '0;
        c_cout  = 1'b0;
        c_oflow = 1'b0;
        c_err   = 1'b0;
        c_g     = 1'b0;
        c_e     = 1'b0;
        c_l     = 1'b0;
        w_t     = '0;
        w_lw    = '0;
        w_rot   = '0;
        w_add   = 1'b0;
        w_sub   = 1'b0;
        w_log   = 1'b0;
        if (w_mode) begin
            case (w_cmd)
                A_ADD:     begin w_t = {1'b0, w_a} + {1'b0, w_b}; w_add = 1'b1; end
                A_SUB:     begin w_t = {1'b0, w_a} - {1'b0, w_b}; w_sub = 1'b1; end
                A_ADD_CIN: begin w_t = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin}; w_add = 1'b1; end
                A_SUB_CIN: begin w_t = {1'b0, w_a} - {1'b0, w_b} - {{WIDTH{1'b0}}, w_cin}; w_sub = 1'b1; end
                A_INC_A:   begin w_t = {1'b0, w_a} + K1; w_add = 1'b1; end
                A_DEC_A:   begin w_t = {1'b0, w_a} - K1; w_sub = 1'b1; end
                A_INC_B:   begin w_t = {1'b0, w_b} + K1; w_add = 1'b1; end
                A_DEC_B:   begin w_t = {1'b0, w_b} - K1; w_sub = 1'b1; end
                A_CMP: begin
                    c_g = (w_a > w_b);
                    c_e = (w_a == w_b);
                    c_l = (w_a < w_b);
                end
                A_MUL_INC, A_MUL_SHL: ;
                default: c_err = 1'b1;
            endcase
        end else begin
            w_log = 1'b1;
            case (w_cmd)
                L_AND:    w_lw = w_a & w_b;
                L_NAND:   w_lw = ~(w_a & w_b);
                L_OR:     w_lw = w_a | w_b;
                L_NOR:    w_lw = ~(w_a | w_b);
                L_XOR:    w_lw = w_a ^ w_b;
                L_XNOR:   w_lw = ~(w_a ^ w_b);
                L_NOT_A:  w_lw = ~w_a;
                L_NOT_B:  w_lw = ~w_b;
                L_SHR1_A: w_lw = {1'b0, w_a[WIDTH-1:1]};
                L_SHL1_A: w_lw = {w_a[WIDTH-2:0], 1'b0};
                L_SHR1_B: w_lw = {1'b0, w_b[WIDTH-1:1]};
                L_SHL1_B: w_lw = {w_b[WIDTH-2:0], 1'b0};
                L_ROL: begin
                    if (|w_b[WIDTH-1:SH_W]) c_err = 1'b1;
                    else begin
                        w_rot = {w_a, w_a} << w_b[SH_W-1:0];
                        w_lw  = w_rot[2*WIDTH-1:WIDTH];
                    end
                end
                L_ROR: begin
                    if (|w_b[WIDTH-1:SH_W]) c_err = 1'b1;
                    else begin
                        w_rot = {w_a, w_a} >> w_b[SH_W-1:0];
                        w_lw  = w_rot[WIDTH-1:0];
                    end
                end
                default: c_err = 1'b1;
            endcase
        end
        if (w_log) c_res = {{WIDTH{1'b0}}, w_lw};
        if (w_add) begin
            c_cout = w_t[WIDTH];
`ifdef ALU_SAT_EN
            c_res = w_t[WIDTH] ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_t[WIDTH-1:0]};
`else
            c_res = {{(WIDTH-1){1'b0}}, w_t};
`endif
        end
        if (w_sub) begin
            c_oflow = w_t[WIDTH];
`ifdef ALU_SAT_EN
            c_res = w_t[WIDTH] ? '0 : {{WIDTH{1'b0}}, w_t[WIDTH-1:0]};
`else
            c_res = {{WIDTH{1'b0}}, w_t[WIDTH-1:0]};
`endif
        end
        if (w_tmo) begin
            c_res   = '0;
            c_cout  = 1'b0;
            c_oflow = 1'b0;
            c_err   = 1'b1;
            c_g     = 1'b0;
            c_e     = 1'b0;
            c_l     = 1'b0;
        end
    end

    // State, operand latches and result registers; a finished multiply is folded
    // into the result registers so it holds after its pulse
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cmd   <= '0;
            r_mode  <= 1'b0;
            r_cin   <= 1'b0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_oflow <= 1'b0;
            r_err   <= 1'b0;
            r_g     <= 1'b0;
            r_e     <= 1'b0;
            r_l     <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_ce) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_lat_a) r_a <= i_op_a;
            if (w_lat_b) r_b <= i_op_b;
            if (w_lat_ctl) begin
                r_cmd  <= i_cmd;
                r_mode <= i_mode;
                r_cin  <= i_cin;
            end
            r_valid <= w_sc_go;
            if (w_sc_go) begin
                r_res   <= c_res;
                r_cout  <= c_cout;
                r_oflow <= c_oflow;
                r_err   <= c_err;
                r_g     <= c_g;
                r_e     <= c_e;
                r_l     <= c_l;
            end else if (w_mul_vld) begin
                r_res   <= w_mul_p;
                r_cout  <= 1'b0;
                r_oflow <= 1'b0;
                r_err   <= 1'b0;
                r_g     <= 1'b0;
                r_e     <= 1'b0;
                r_l     <= 1'b0;
            end
        end
    end

    assign o_res       = w_mul_vld ? w_mul_p : r_res;
    assign o_cout      = ~w_mul_vld & r_cout;
    assign o_oflow     = ~w_mul_vld & r_oflow;
    assign o_err       = ~w_mul_vld & r_err;
    assign o_g         = ~w_mul_vld & r_g;
    assign o_e         = ~w_mul_vld & r_e;
    assign o_l         = ~w_mul_vld & r_l;
    assign o_res_valid = i_ce & (r_valid | w_mul_vld);
    assign o_busy      = w_busy;

endmodule

// File: tb/tb_alu_param_core.sv
// Directed bench for alu_param_core (WIDTH=8, TIMEOUT=16). Expectations follow
// ALU_SAT_EN when the bench is built with that macro.
module tb_alu_param_core;

`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ce, mode, cin;
    logic [3:0]  cmd;
    logic [1:0]  iv;
    logic [7:0]  a, b;
    logic [15:0] res;
    logic        res_valid, busy, cout, oflow, err, g, e, l;
    int          n_chk = 0;
    int          n_fail = 0;

    alu_param_core #(.WIDTH(8), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_mode(mode), .i_cmd(cmd),
        .i_inp_valid(iv), .i_op_a(a), .i_op_b(b), .i_cin(cin),
        .o_res(res), .o_res_valid(res_valid), .o_busy(busy), .o_cout(cout),
        .o_oflow(oflow), .o_err(err), .o_g(g), .o_e(e), .o_l(l)
    );

    always #5 clk = ~clk;

    // {valid, busy, res, cout, oflow, err, G, E, L}
    function automatic logic [23:0] pk(input logic v, input logic bz, input logic [15:0] r,
                                       input logic co, input logic of, input logic er,
                                       input logic [2:0] gel);
        return {v, bz, r, co, of, er, gel};
    endfunction

    function automatic logic [23:0] obs();
        return {res_valid, busy, res, cout, oflow, err, g, e, l};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] v,
                         input logic [7:0] aa, input logic [7:0] bb, input logic ci);
        mode = m; cmd = c; iv = v; a = aa; b = bb; cin = ci;
    endtask

    task automatic issue(input logic m, input logic [3:0] c, input logic [1:0] v,
                         input logic [7:0] aa, input logic [7:0] bb, input logic ci);
        drive(m, c, v, aa, bb, ci);
        step();
        iv = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (obs() !== 24'h0) begin n_fail++; $display("FAIL reset_outputs got %h want %h", obs(), 24'h0); end
        rst = 1'b1;
    endtask

    task automatic test_arith();
        logic [23:0] x;
        issue(1, 0, 2'b11, 8'hFF, 8'h01, 0); // ADD
        x = pk(1, 0, SAT ? 16'h00FF : 16'h0100, 1, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL add_carry got %h want %h", obs(), x); end
        step();
        x = pk(0, 0, SAT ? 16'h00FF : 16'h0100, 1, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL add_hold got %h want %h", obs(), x); end
        issue(1, 2, 2'b11, 8'h10, 8'h20, 1); // ADD_CIN
        x = pk(1, 0, 16'h0031, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL add_cin got %h want %h", obs(), x); end
        issue(1, 1, 2'b11, 8'h03, 8'h05, 0); // SUB borrow
        x = pk(1, 0, SAT ? 16'h0000 : 16'h00FE, 0, 1, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL sub_borrow got %h want %h", obs(), x); end
        issue(1, 3, 2'b11, 8'h10, 8'h05, 1); // SUB_CIN
        x = pk(1, 0, 16'h000A, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL sub_cin got %h want %h", obs(), x); end
        issue(1, 5, 2'b01, 8'h00, 8'h00, 0); // DEC_A of 0, A only
        x = pk(1, 0, SAT ? 16'h0000 : 16'h00FF, 0, 1, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL dec_zero got %h want %h", obs(), x); end
        issue(1, 6, 2'b10, 8'h00, 8'h0F, 0); // INC_B, B only
        x = pk(1, 0, 16'h0010, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL inc_b got %h want %h", obs(), x); end
        issue(1, 11, 2'b11, 8'h01, 8'h01, 0); // illegal arith
        x = pk(1, 0, 16'h0000, 0, 0, 1, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL arith_illegal got %h want %h", obs(), x); end
    endtask

    task automatic test_cmp();
        logic [23:0] x;
        issue(1, 8, 2'b11, 8'h09, 8'h09, 0);
        x = pk(1, 0, 16'h0000, 0, 0, 0, 3'b010);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL cmp_eq got %h want %h", obs(), x); end
        issue(1, 8, 2'b11, 8'h0A, 8'h09, 0);
        x = pk(1, 0, 16'h0000, 0, 0, 0, 3'b100);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL cmp_gt got %h want %h", obs(), x); end
        issue(1, 8, 2'b11, 8'h03, 8'h05, 0);
        x = pk(1, 0, 16'h0000, 0, 0, 0, 3'b001);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL cmp_lt got %h want %h", obs(), x); end
    endtask

    task automatic test_logic();
        logic [23:0] x;
        issue(0, 1, 2'b11, 8'hFF, 8'h0F, 0); // NAND
        x = pk(1, 0, 16'h00F0, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL nand got %h want %h", obs(), x); end
        issue(0, 5, 2'b11, 8'hF0, 8'h3C, 0); // XNOR
        x = pk(1, 0, 16'h0033, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL xnor got %h want %h", obs(), x); end
        issue(0, 12, 2'b11, 8'h81, 8'h01, 0); // ROL by 1
        x = pk(1, 0, 16'h0003, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL rol1 got %h want %h", obs(), x); end
        issue(0, 13, 2'b11, 8'h81, 8'h01, 0); // ROR by 1
        x = pk(1, 0, 16'h00C0, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL ror1 got %h want %h", obs(), x); end
        issue(0, 12, 2'b11, 8'h5A, 8'h00, 0); // ROL by 0
        x = pk(1, 0, 16'h005A, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL rol0 got %h want %h", obs(), x); end
        issue(0, 12, 2'b11, 8'h81, 8'h09, 0); // illegal rotate amount
        x = pk(1, 0, 16'h0000, 0, 0, 1, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL rol_bad_amt got %h want %h", obs(), x); end
        issue(0, 15, 2'b11, 8'h12, 8'h34, 0); // illegal logical
        x = pk(1, 0, 16'h0000, 0, 0, 1, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL logic_illegal got %h want %h", obs(), x); end
        issue(0, 9, 2'b01, 8'h81, 8'h00, 0); // SHL1_A, A only
        x = pk(1, 0, 16'h0002, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL shl1_a got %h want %h", obs(), x); end
    endtask

    task automatic test_mul();
        logic [23:0] x;
        issue(1, 9, 2'b11, 8'h03, 8'h04, 0); // MUL_INC
        n_chk++; if ({res_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL mul_busy got %b want 01", {res_valid, busy}); end
        issue(1, 0, 2'b11, 8'h01, 8'h01, 0); // ADD offered while busy
        x = pk(1, 0, 16'h0014, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL mul_inc got %h want %h", obs(), x); end
        step();
        x = pk(0, 0, 16'h0014, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL busy_ignore got %h want %h", obs(), x); end
        issue(1, 10, 2'b11, 8'h81, 8'h03, 0); // MUL_SHL wraps A<<1
        step();
        x = pk(1, 0, 16'h0006, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL mul_shl got %h want %h", obs(), x); end
        issue(1, 9, 2'b11, 8'h0F, 8'h10, 0); // 16*17
        step();
        x = pk(1, 0, 16'h0110, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL mul_wide got %h want %h", obs(), x); end
    endtask

    task automatic test_split();
        logic [23:0] x;
        logic        saw;
        issue(1, 0, 2'b01, 8'h05, 8'h00, 0); // A first, ADD
        saw = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (k == 5) drive(0, 4'hF, 2'b01, 8'h20, 8'h00, 1); // stray A and fields, ignored
            else iv = 2'b00;
            saw |= res_valid;
            step();
        end
        n_chk++; if (saw !== 1'b0) begin n_fail++; $display("FAIL split_early got %b want 0", saw); end
        issue(1, 4'hF, 2'b10, 8'h00, 8'h07, 1);
        x = pk(1, 0, 16'h000C, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL split_ab got %h want %h", obs(), x); end
        issue(1, 1, 2'b10, 8'h00, 8'h05, 0); // B first, SUB
        issue(1, 0, 2'b01, 8'h03, 8'h00, 0);
        x = pk(1, 0, SAT ? 16'h0000 : 16'h00FE, 0, 1, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL split_ba got %h want %h", obs(), x); end
    endtask

    task automatic test_timeout();
        logic [23:0] x;
        logic        saw;
        issue(1, 0, 2'b01, 8'h05, 8'h00, 0);
        saw = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            saw |= res_valid;
            step();
        end
        n_chk++; if (saw !== 1'b0) begin n_fail++; $display("FAIL tmo_early got %b want 0", saw); end
        x = pk(1, 0, 16'h0000, 0, 0, 1, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL tmo_err got %h want %h", obs(), x); end
        issue(1, 4, 2'b01, 8'h41, 8'h00, 0); // back in IDLE: INC_A runs at once
        x = pk(1, 0, 16'h0042, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL tmo_idle got %h want %h", obs(), x); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] x;
        logic        saw;
        issue(1, 0, 2'b01, 8'h05, 8'h00, 0); // park in WAIT_B
        step();
        rst = 1'b0; #1;
        n_chk++; if (obs() !== 24'h0) begin n_fail++; $display("FAIL rst_wait got %h want %h", obs(), 24'h0); end
        #1 rst = 1'b1;
        drive(1, 0, 2'b10, 8'h00, 8'h07, 0); // would finish a WAIT_B; in IDLE it parks in WAIT_A
        saw = 1'b0;
        step(); iv = 2'b00; saw |= res_valid;
        step(); saw |= res_valid;
        n_chk++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rst_wait_ghost got %b want 0", saw); end
        issue(1, 0, 2'b01, 8'h01, 8'h00, 0);
        x = pk(1, 0, 16'h0008, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL rst_idle got %h want %h", obs(), x); end
        issue(1, 9, 2'b11, 8'h03, 8'h04, 0); // multiply in flight
        rst = 1'b0; #1;
        n_chk++; if (obs() !== 24'h0) begin n_fail++; $display("FAIL rst_mul got %h want %h", obs(), 24'h0); end
        #1 rst = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 3; k++) begin step(); saw |= res_valid | busy; end
        n_chk++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rst_mul_ghost got %b want 0", saw); end
    endtask

    task automatic test_ce();
        logic [23:0] x;
        logic        saw;
        issue(1, 9, 2'b11, 8'h03, 8'h04, 0);
        ce = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 5; k++) begin step(); saw |= res_valid; end
        ce = 1'b1; #1;
        n_chk++; if ({saw, res_valid, busy} !== 3'b001) begin n_fail++; $display("FAIL ce_freeze got %b want 001", {saw, res_valid, busy}); end
        step();
        x = pk(1, 0, 16'h0014, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL ce_mul_late got %h want %h", obs(), x); end
        issue(1, 0, 2'b11, 8'h01, 8'h01, 0);
        ce = 1'b0; #1;
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL ce_mask got %b want 0", res_valid); end
        ce = 1'b1; #1;
        x = pk(1, 0, 16'h0002, 0, 0, 0, 3'b000);
        n_chk++; if (obs() !== x) begin n_fail++; $display("FAIL ce_unmask got %h want %h", obs(), x); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_cmp();
        test_logic();
        test_mul();
        test_split();
        test_timeout();
        test_reset_mid();
        test_ce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
